updown_key_pulser: RTL and testbench
====================================

Name: updown_key_pulser

Overview:
- Driver side of the up/down counter increment interface: turns two raw push-button levels into clean single-cycle i_up/i_down-style step pulses.
- Synchronizes and debounces both keys, emits one pulse per press, then auto-repeats while a key is held.
- Sits between the board buttons and the seconds/minutes counters of the clock; its outputs connect directly to the counters' up/down step inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-stable cycles needed to accept a press or release (≥1).
- HOLD_DELAY, 50: cycles from the first pulse to the first auto-repeat pulse (≥2).
- REPEAT_PERIOD, 10: cycles between auto-repeat pulses (≥2).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_key_up  input  1  raw, asynchronous, active-high up button.
- i_key_down  input  1  raw, asynchronous, active-high down button.
- o_up  output  1  one-cycle step-up pulse.
- o_down  output  1  one-cycle step-down pulse.
- o_repeating  output  1  high while in auto-repeat.

Behaviour:
- Reset: async, clears all flops. o_up=0, o_down=0, o_repeating=0, FSM=IDLE, all counters 0, synchronizers 0.
- Per key: 2-flop synchronizer, then debouncer.
  - Debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle (synced value equals the debounced level) clears the debounce counter.
- Press latency: with the raw key first sampled high at edge 0 and held, o_up is high in the cycle following edge 2+DEBOUNCE_CYCLES (edge 6 at defaults), for exactly 1 cycle.
- FSM states: IDLE, HOLD, REPEAT, LOCKOUT.
  - IDLE → HOLD: exactly one debounced key rises. Emit one pulse on that key's output in the same cycle as the debounced rise. Load the timer with HOLD_DELAY.
  - HOLD: timer decrements each cycle. At expiry, emit a pulse, go to REPEAT, load REPEAT_PERIOD.
  - REPEAT: o_repeating=1. Emit a pulse every REPEAT_PERIOD cycles.
  - HOLD/REPEAT → IDLE: the active key's debounced level falls. No pulse on release. Timer cleared.
  - IDLE → LOCKOUT: both debounced levels rise in the same cycle. No pulse.
  - LOCKOUT → IDLE: both debounced levels are low.
- Second key during HOLD/REPEAT: ignored. The active key keeps its pulses. No pulse ever occurs on the other output. When the active key releases while the other is still held → LOCKOUT.
- Mutual exclusion: o_up and o_down are never high in the same cycle.
- Glitches: raw glitches shorter than DEBOUNCE_CYCLES, on press or release, produce no events. Repeat timing continues uninterrupted through them.
- Timer width: $clog2(max(HOLD_DELAY, REPEAT_PERIOD)+1). Counters saturate and never wrap.
- Mid-operation reset: outputs drop immediately (async). After reset release, a still-held key is treated as a new press and follows the full press latency.

Optional Feature:
- Macro: UPDOWN_KEY_ACCEL_EN.
- With the macro defined: after 8 auto-repeat pulses in one hold, the period becomes REPEAT_PERIOD/2 (minimum 1) until release. A 4-bit saturating repeat count is added and is cleared on entering IDLE.
- Without the macro: the period stays fixed at REPEAT_PERIOD and the repeat-count logic is absent.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2, LOCKOUT=2'd3.
  - ACCEL_THRESHOLD=8.
  - Timer-width function/localparam.
- Sub-module key_debouncer (parameter DEBOUNCE_CYCLES) holds the synchronizer and debouncer.
  - Outputs: o_level, plus o_rise/o_fall one-cycle events.
  - Instantiated once per key.
- The top level holds the FSM, timer and optional acceleration.

Test Plan (defaults):
- i_key_up high for 20 cycles from edge 0 → one o_up pulse at edge 6; o_down stays 0; no further pulses; FSM returns to IDLE 6 cycles after release.
- i_key_up held 120 cycles → o_up pulses at edges 6, 56, 66, 76, 86, 96, 106, 116; o_repeating=1 from edge 56 until the debounced release.
- i_key_down pulses of 3 cycles high / 3 cycles low, repeated 10 times → no o_down pulse; a 1-cycle low glitch during REPEAT does not shift the next pulse.
- i_key_up and i_key_down rise at the same edge, held 100 cycles → no pulses; releasing only up leaves the block in LOCKOUT with no pulses; releasing both returns it to IDLE.
- Reset (i_rstn=0 for 1 cycle) asserted during REPEAT with i_key_up still held → o_up and o_repeating drop 0 immediately; the next o_up comes 6 edges after reset release.
- UPDOWN_KEY_ACCEL_EN defined, i_key_up held 200 cycles → the first 8 repeats are 10 cycles apart, the following repeats 5 cycles apart; without the macro, the repeats stay 10 cycles apart.

Source files
------------

// File: rtl/updown_key_pulser_pkg.sv
// Shared definitions for the up/down key pulser: FSM encodings, key event bundle,
// acceleration constants and timer sizing helpers.
package updown_key_pulser_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    localparam int unsigned ACCEL_THRESHOLD = 8;
    localparam int unsigned REPEAT_CNT_W    = 4;

    // Debounced view of one key as seen by the FSM
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } key_evt_t;

    // Timer must hold the larger of the two reload values without wrapping
    function automatic int unsigned timer_width(input int unsigned hold_delay,
                                                input int unsigned repeat_period);
        int unsigned mx;
        mx = (hold_delay > repeat_period) ? hold_delay : repeat_period;
        return $clog2(mx + 1);
    endfunction

    // Accelerated repeat period, never below one cycle
    function automatic int unsigned fast_period(input int unsigned repeat_period);
        return ((repeat_period / 2) < 1) ? 1 : (repeat_period / 2);
    endfunction

endpackage

// File: rtl/updown_key_pulser_debouncer.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button;
// reports the clean level and single-cycle rise/fall events.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Metastability guard for the asynchronous button input
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], i_key};
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (sync[1] == o_level) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt     <= '0;
                o_level <= sync[1];
                o_rise  <= sync[1];
                o_fall  <= ~sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/updown_key_pulser.sv
// Turns two raw buttons into clean single-cycle up/down step pulses with hold-to-repeat.
// Optional repeat acceleration is enabled by defining UPDOWN_KEY_ACCEL_EN.
module updown_key_pulser
    import updown_key_pulser_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_DELAY      = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key_up,
    input  logic i_key_down,
    output logic o_up,
    output logic o_down,
    output logic o_repeating
);

    localparam int unsigned TW = timer_width(HOLD_DELAY, REPEAT_PERIOD);

    key_evt_t      ev_up;
    key_evt_t      ev_dn;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [TW-1:0] period;
    logic          active;
    logic          active_nxt;
    logic          fire;
    logic          act_fall;
    logic          oth_level;
    logic          up_nxt;
    logic          down_nxt;
`ifdef UPDOWN_KEY_ACCEL_EN
    logic [REPEAT_CNT_W-1:0] rcnt;
    logic [REPEAT_CNT_W-1:0] rcnt_nxt;
    logic [REPEAT_CNT_W-1:0] rcnt_inc;
`endif

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_up (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_key  (i_key_up),
        .o_level(ev_up.level),
        .o_rise (ev_up.rise),
        .o_fall (ev_up.fall)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_dn (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_key  (i_key_down),
        .o_level(ev_dn.level),
        .o_rise (ev_dn.rise),
        .o_fall (ev_dn.fall)
    );

    // Next-state, timer and pulse decision; active=0 selects the up key
    always_comb begin
        state_nxt  = state;
        active_nxt = active;
        timer_nxt  = (timer != '0) ? (timer - TW'(1)) : '0;
        fire       = 1'b0;
        act_fall   = active ? ev_dn.fall  : ev_up.fall;
        oth_level  = active ? ev_up.level : ev_dn.level;
`ifdef UPDOWN_KEY_ACCEL_EN
        rcnt_nxt   = rcnt;
        rcnt_inc   = (rcnt == '1) ? rcnt : (rcnt + REPEAT_CNT_W'(1));
        period     = (32'(rcnt_inc) >= ACCEL_THRESHOLD) ? TW'(fast_period(REPEAT_PERIOD))
                                                        : TW'(REPEAT_PERIOD);
`else
        period     = TW'(REPEAT_PERIOD);
`endif

        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (ev_up.rise && ev_dn.rise) begin
                    state_nxt = ST_LOCKOUT;
                end else if (ev_up.rise || ev_dn.rise) begin
                    state_nxt  = ST_HOLD;
                    active_nxt = ev_dn.rise;
                    fire       = 1'b1;
                    timer_nxt  = TW'(HOLD_DELAY);
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // Release wins over a coincident repeat expiry
                if (act_fall) begin
                    timer_nxt = '0;
                    state_nxt = oth_level ? ST_LOCKOUT : ST_IDLE;
                end else if (timer <= TW'(1)) begin
                    fire      = 1'b1;
                    timer_nxt = period;
                    state_nxt = ST_REPEAT;
`ifdef UPDOWN_KEY_ACCEL_EN
                    rcnt_nxt  = rcnt_inc;
`endif
                end
            end
            ST_LOCKOUT: begin
                timer_nxt = '0;
                if (!ev_up.level && !ev_dn.level) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        up_nxt   = fire & ~active_nxt;
        down_nxt = fire & active_nxt;
`ifdef UPDOWN_KEY_ACCEL_EN
        if ((state_nxt != ST_HOLD) && (state_nxt != ST_REPEAT)) begin
            rcnt_nxt = '0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            timer       <= '0;
            active      <= 1'b0;
            o_up        <= 1'b0;
            o_down      <= 1'b0;
            o_repeating <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            active      <= active_nxt;
            o_up        <= up_nxt;
            o_down      <= down_nxt;
            o_repeating <= (state_nxt == ST_REPEAT);
        end
    end

`ifdef UPDOWN_KEY_ACCEL_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_updown_key_pulser.sv
// Bench for updown_key_pulser: directed and random key sequences against a
// cycle-indexed reference model, plus absolute pulse-timing checks.
module tb_updown_key_pulser;

    localparam int DEB = 4;
    localparam int HD  = 50;
    localparam int RP  = 10;
    localparam int M_IDLE = 0, M_HOLD = 1, M_REP = 2, M_LOCK = 3;

    logic clk = 1'b0;
    logic rstn;
    logic key_up;
    logic key_down;
    logic up;
    logic down;
    logic repeating;

    int passed = 0;
    int total  = 0;

    // Reference model state
    bit q_up[$];
    bit q_dn[$];
    bit lvl[2];
    int mis[2];
    bit rise[2];
    bit fall[2];
    int mode;
    int act;
    int reps;
    int cyc;
    int due;
    bit e_up, e_dn, e_rep;

    // Pulse timestamps relative to phase start
    int up_q[$];
    int dn_q[$];
    int rel;

    updown_key_pulser #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_DELAY     (HD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_key_up   (key_up),
        .i_key_down (key_down),
        .o_up       (up),
        .o_down     (down),
        .o_repeating(repeating)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d (rel edge %0d)", tag, obs, exp, rel);
    endtask

    function automatic void model_reset();
        q_up.delete();
        q_dn.delete();
        for (int k = 0; k < 2; k++) begin
            lvl[k] = 1'b0; mis[k] = 0; rise[k] = 1'b0; fall[k] = 1'b0;
        end
        mode = M_IDLE; act = 0; reps = 0; cyc = 0; due = 0;
        e_up = 1'b0; e_dn = 1'b0; e_rep = 1'b0;
    endfunction

    // One rising edge: decide using previously debounced state, then debounce new samples
    function automatic void model_edge(input bit u, input bit d);
        bit emit;
        bit s[2];
        int per;
        emit = 1'b0;
`ifdef UPDOWN_KEY_ACCEL_EN
        per = ((reps + 1) >= 8) ? (((RP / 2) < 1) ? 1 : (RP / 2)) : RP;
`else
        per = RP;
`endif
        case (mode)
            M_IDLE: begin
                if (rise[0] && rise[1]) mode = M_LOCK;
                else if (rise[0] || rise[1]) begin
                    act = rise[1] ? 1 : 0;
                    emit = 1'b1;
                    mode = M_HOLD;
                    due = cyc + HD;
                    reps = 0;
                end
            end
            M_HOLD, M_REP: begin
                if (fall[act]) mode = lvl[1 - act] ? M_LOCK : M_IDLE;
                else if (cyc == due) begin
                    emit = 1'b1;
                    mode = M_REP;
                    due = cyc + per;
                    reps = (reps < 15) ? reps + 1 : 15;
                end
            end
            default: begin
                if (!lvl[0] && !lvl[1]) mode = M_IDLE;
            end
        endcase
        e_up  = emit && (act == 0);
        e_dn  = emit && (act == 1);
        e_rep = (mode == M_REP);

        // Synchronized value is the raw sample from two edges back
        s[0] = (q_up.size() == 2) ? q_up[0] : 1'b0;
        s[1] = (q_dn.size() == 2) ? q_dn[0] : 1'b0;
        q_up.push_back(u);
        q_dn.push_back(d);
        if (q_up.size() > 2) void'(q_up.pop_front());
        if (q_dn.size() > 2) void'(q_dn.pop_front());
        for (int k = 0; k < 2; k++) begin
            rise[k] = 1'b0;
            fall[k] = 1'b0;
            if (s[k] != lvl[k]) begin
                mis[k]++;
                if (mis[k] == DEB) begin
                    lvl[k] = s[k];
                    rise[k] = s[k];
                    fall[k] = !s[k];
                    mis[k] = 0;
                end
            end else begin
                mis[k] = 0;
            end
        end
        cyc++;
    endfunction

    task automatic step(input bit u, input bit d);
        key_up = u;
        key_down = d;
        @(posedge clk);
        model_edge(u, d);
        #1;
        check("o_up", 32'(up), 32'(e_up));
        check("o_down", 32'(down), 32'(e_dn));
        check("o_repeating", 32'(repeating), 32'(e_rep));
        check("mutex", 32'(up & down), 32'd0);
        if (up === 1'b1) up_q.push_back(rel);
        if (down === 1'b1) dn_q.push_back(rel);
        rel++;
    endtask

    task automatic hold(input bit u, input bit d, input int n);
        repeat (n) step(u, d);
    endtask

    task automatic begin_phase();
        up_q.delete();
        dn_q.delete();
        rel = 0;
    endtask

    function automatic int first_up();
        return (up_q.size() > 0) ? up_q[0] : -1;
    endfunction

    task automatic check_repeat_list(input string tag);
        int exp_e[8];
        exp_e = '{6, 56, 66, 76, 86, 96, 106, 116};
        check({tag, "_count"}, 32'(up_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_edge"}, 32'((i < up_q.size()) ? up_q[i] : -1), 32'(exp_e[i]));
        end
    endtask

    initial begin
        int gap_exp;
        bit ru, rd;
        rel = 0;
        rstn = 1'b0;
        key_up = 1'b0;
        key_down = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_o_up", 32'(up), 32'd0);
        check("rst_o_down", 32'(down), 32'd0);
        check("rst_o_repeating", 32'(repeating), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single short press
        begin_phase();
        hold(1, 0, 20);
        hold(0, 0, 15);
        check("short_count", 32'(up_q.size()), 32'd1);
        check("short_edge", 32'(first_up()), 32'd6);
        check("short_down", 32'(dn_q.size()), 32'd0);

        // Long hold with auto-repeat
        begin_phase();
        hold(1, 0, 120);
        hold(0, 0, 15);
        check_repeat_list("hold120");

        // Bouncing down key never accepted
        begin_phase();
        repeat (10) begin
            hold(0, 1, 3);
            hold(0, 0, 3);
        end
        hold(0, 0, 10);
        check("bounce_down", 32'(dn_q.size()), 32'd0);

        // Release glitch during repeat keeps cadence
        begin_phase();
        hold(1, 0, 70);
        hold(0, 0, 1);
        hold(1, 0, 40);
        hold(0, 0, 15);
        check_repeat_list("glitch");

        // Simultaneous press locks out; single release stays locked
        begin_phase();
        hold(1, 1, 100);
        hold(0, 1, 20);
        hold(0, 0, 15);
        check("lock_up", 32'(up_q.size()), 32'd0);
        check("lock_down", 32'(dn_q.size()), 32'd0);

        // Second key during hold is ignored, release of first goes to lockout
        begin_phase();
        hold(1, 0, 30);
        hold(1, 1, 60);
        hold(0, 1, 20);
        hold(0, 0, 15);
        check("second_up", 32'(up_q.size()), 32'd5);
        check("second_down", 32'(dn_q.size()), 32'd0);

        // Reset during repeat with key still held
        begin_phase();
        hold(1, 0, 70);
        check("pre_reset_rep", 32'(repeating), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_o_up", 32'(up), 32'd0);
        check("async_o_down", 32'(down), 32'd0);
        check("async_o_repeating", 32'(repeating), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        begin_phase();
        hold(1, 0, 30);
        hold(0, 0, 15);
        check("post_reset_edge", 32'(first_up()), 32'd6);

        // Long hold: repeat spacing, accelerated when the feature is built in
        begin_phase();
        hold(1, 0, 200);
        hold(0, 0, 15);
        check("long_count", 32'(up_q.size()), 32'(`ifdef UPDOWN_KEY_ACCEL_EN 24 `else 16 `endif));
        check("long_first_gap", 32'((up_q.size() > 1) ? up_q[1] - up_q[0] : -1), 32'(HD));
        for (int i = 2; i < up_q.size(); i++) begin
`ifdef UPDOWN_KEY_ACCEL_EN
            gap_exp = (i >= 9) ? RP / 2 : RP;
`else
            gap_exp = RP;
`endif
            check("long_gap", 32'(up_q[i] - up_q[i - 1]), 32'(gap_exp));
        end

        // Random key segments against the model
        begin_phase();
        repeat (40) begin
            ru = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            hold(ru, rd, $urandom_range(1, 70));
        end
        hold(0, 0, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
